// File: rtl/fifo_arb_pkg.sv
// rtl/fifo_arb_pkg.sv - shared types and helpers for the FIFO write-port arbiter
package fifo_arb_pkg;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_BURST = 1'b1
    } arb_state_t;

    localparam int DEFAULT_MAX_BURST = 4;

    // Index width for n requesters; a single requester still needs one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin picker: first set req bit at or above rr_ptr, wrapping
module rr_pick
    import fifo_arb_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = idx_width(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] rr_ptr,
    output logic [IW-1:0] winner,
    output logic          any_valid
);

    function automatic logic [IW-1:0] wrap_idx(input logic [IW-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= N) s = s - N;
        return IW'(s);
    endfunction

    // Scan from the far end down so the smallest offset from rr_ptr is the last to win.
    always_comb begin
        winner    = '0;
        any_valid = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[wrap_idx(rr_ptr, i)]) begin
                winner    = wrap_idx(rr_ptr, i);
                any_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - round-robin burst arbiter sharing one FIFO write port among N_REQ producers
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int N_REQ     = 4,
    parameter int DW        = 8,
    parameter int MAX_BURST = DEFAULT_MAX_BURST
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [N_REQ-1:0]              req,
    input  logic [N_REQ*DW-1:0]           req_data,
    input  logic                          fifo_full,
    input  logic                          fifo_threshold,
    output logic                          wrEn,
    output logic [DW-1:0]                 data_in,
    output logic [N_REQ-1:0]              ack,
    output logic [idx_width(N_REQ)-1:0]   gnt_id,
    output logic                          busy
);

    localparam int IW = idx_width(N_REQ);
    localparam int BW = $clog2(MAX_BURST + 1);

    arb_state_t    state_q, state_d;
    logic [IW-1:0] gnt_q, gnt_d;
    logic [IW-1:0] rr_q, rr_d;
    logic [BW-1:0] beat_q, beat_d;
    logic [BW-1:0] beat_inc;
    logic [IW-1:0] nxt_ptr;
    logic [IW-1:0] winner;
    logic          any_valid;

    rr_pick #(
        .N  (N_REQ),
        .IW (IW)
    ) u_rr_pick (
        .req       (req),
        .rr_ptr    (rr_q),
        .winner    (winner),
        .any_valid (any_valid)
    );

    assign beat_inc = beat_q + BW'(1);
    assign nxt_ptr  = (gnt_q == IW'(N_REQ - 1)) ? '0 : gnt_q + IW'(1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ARB_IDLE;
            gnt_q   <= '0;
            rr_q    <= '0;
            beat_q  <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            rr_q    <= rr_d;
            beat_q  <= beat_d;
        end
    end

    // A full FIFO only stalls the burst; losing req, hitting the burst cap or a
    // beat accepted above half full ends it and rotates priority past the winner.
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        rr_d    = rr_q;
        beat_d  = beat_q;
        case (state_q)
            ARB_IDLE: begin
                if (any_valid && !fifo_full) begin
                    state_d = ARB_BURST;
                    gnt_d   = winner;
                    beat_d  = '0;
                end
            end
            ARB_BURST: begin
                if (!req[gnt_q]) begin
                    state_d = ARB_IDLE;
                    rr_d    = nxt_ptr;
                end else if (wrEn) begin
                    beat_d = beat_inc;
                    if ((beat_inc == BW'(MAX_BURST)) || fifo_threshold) begin
                        state_d = ARB_IDLE;
                        rr_d    = nxt_ptr;
                    end
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_comb begin
        busy    = (state_q == ARB_BURST);
        wrEn    = busy & req[gnt_q] & ~fifo_full;
        ack     = wrEn ? (N_REQ'(1) << gnt_q) : '0;
        data_in = req_data[int'(gnt_q) * DW +: DW];
        gnt_id  = gnt_q;
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb/tb_fifo_wr_arbiter.sv - directed scoreboard bench for fifo_wr_arbiter with a behavioural FIFO model
module tb_fifo_wr_arbiter;

    localparam int N_REQ     = 4;
    localparam int DW        = 8;
    localparam int MAX_BURST = 4;

    logic                clk = 1'b0;
    logic                reset;
    logic [N_REQ-1:0]    req;
    logic [N_REQ*DW-1:0] req_data;
    logic                fifo_full;
    logic                fifo_threshold;
    logic                wrEn;
    logic [DW-1:0]       data_in;
    logic [N_REQ-1:0]    ack;
    logic [1:0]          gnt_id;
    logic                busy;

    fifo_wr_arbiter #(
        .N_REQ     (N_REQ),
        .DW        (DW),
        .MAX_BURST (MAX_BURST)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .req            (req),
        .req_data       (req_data),
        .fifo_full      (fifo_full),
        .fifo_threshold (fifo_threshold),
        .wrEn           (wrEn),
        .data_in        (data_in),
        .ack            (ack),
        .gnt_id         (gnt_id),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int            id;
        logic [DW-1:0] d;
    } exp_t;

    exp_t          exp_q[$];
    int            rem[N_REQ];
    logic [DW-1:0] nxt[N_REQ];
    int            fcnt;
    int            mode;
    bit            pop_once;
    bit            thr_en;
    int            checks;
    int            failures;
    bit            s_wr;
    bit            s_busy;
    int            s_gnt;
    bit            prev_wr;
    logic [31:0]   mask;
    int            cyc;
    int            b_gnt[$];
    int            b_len[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < N_REQ; i++) begin
            req[i] = (rem[i] > 0);
            req_data[i*DW +: DW] = nxt[i];
        end
        fifo_full      = (fcnt >= 16);
        fifo_threshold = thr_en && (fcnt >= 8);
    endtask

    task automatic load(input int i, input int n, input logic [DW-1:0] base);
        rem[i] = n;
        nxt[i] = base;
        for (int k = 0; k < n; k++) exp_q.push_back('{id: i, d: base + DW'(k)});
        drive();
    endtask

    task automatic start_trace();
        prev_wr = 1'b0;
        mask    = '0;
        cyc     = 0;
        b_gnt.delete();
        b_len.delete();
    endtask

    task automatic sample();
        int hit;
        #1;
        s_wr   = wrEn;
        s_busy = busy;
        s_gnt  = int'(gnt_id);
        if (wrEn) begin
            chk("ack_onehot", ack, 32'(1) << gnt_id);
            hit = -1;
            foreach (exp_q[k]) if (hit < 0 && exp_q[k].id == s_gnt) hit = k;
            chk("sb_hit", hit >= 0, 1);
            if (hit >= 0) begin
                chk("sb_data", data_in, exp_q[hit].d);
                exp_q.delete(hit);
            end
            if (!prev_wr || b_gnt.size() == 0 || b_gnt[$] != s_gnt) begin
                b_gnt.push_back(s_gnt);
                b_len.push_back(1);
            end else begin
                b_len[b_len.size()-1] = b_len[b_len.size()-1] + 1;
            end
        end
        if (fifo_full) chk("no_write_full", wrEn, 0);
        if (cyc < 32) mask[cyc] = wrEn;
        cyc++;
        prev_wr = wrEn;
    endtask

    task automatic advance();
        bit p;
        @(posedge clk);
        #1;
        if (s_wr) begin
            rem[s_gnt]--;
            nxt[s_gnt]++;
        end
        p = pop_once || (mode == 1 && fcnt > 0) || (mode == 2 && s_wr);
        fcnt = fcnt + int'(s_wr) - int'(p);
        pop_once = 1'b0;
        chk("fifo_no_overflow", fcnt <= 16, 1);
        drive();
    endtask

    task automatic tick();
        sample();
        advance();
    endtask

    task automatic pulse_reset();
        reset = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    initial begin
        int exp_g[5];
        checks = 0; failures = 0; fcnt = 0; mode = 0; pop_once = 1'b0; thr_en = 1'b1;
        for (int i = 0; i < N_REQ; i++) begin rem[i] = 0; nxt[i] = '0; end
        nxt[0] = 8'hA5;
        reset = 1'b0;
        drive();
        repeat (2) @(posedge clk);
        #2;
        chk("rst_wrEn", wrEn, 0);
        chk("rst_ack", ack, 0);
        chk("rst_busy", busy, 0);
        chk("rst_gnt", gnt_id, 0);
        chk("rst_data_slice0", data_in, 8'hA5);
        @(posedge clk);
        #1;
        reset = 1'b1;
        nxt[0] = '0;

        // Single requester streaming: 4-beat burst, bubble, 2-beat tail.
        start_trace();
        load(0, 6, 8'h10);
        repeat (10) tick();
        chk("t1_ack_cycles", mask, 32'h0DE);
        chk("t1_fifo_count", fcnt, 6);
        chk("t1_sb_empty", exp_q.size(), 0);
        chk("t1_idle", s_busy, 0);

        // Fairness with all four requesting.
        pulse_reset();
        fcnt = 0; mode = 1;
        start_trace();
        load(0, 8, 8'h20);
        load(1, 4, 8'h30);
        load(2, 4, 8'h40);
        load(3, 4, 8'h50);
        repeat (27) tick();
        exp_g = '{0, 1, 2, 3, 0};
        chk("t2_bursts", b_gnt.size(), 5);
        if (b_gnt.size() >= 5) begin
            for (int k = 0; k < 5; k++) begin
                chk("t2_gnt_order", b_gnt[k], exp_g[k]);
                chk("t2_burst_len", b_len[k], 4);
            end
        end
        chk("t2_sb_empty", exp_q.size(), 0);

        // Full stall: FIFO at 15, one pop five cycles in.
        mode = 0; fcnt = 15; thr_en = 1'b0;
        start_trace();
        load(2, 3, 8'h60);
        for (int c = 0; c < 8; c++) begin
            if (c == 5) pop_once = 1'b1;
            sample();
            if (c == 3) begin
                chk("t3_stall_busy", s_busy, 1);
                chk("t3_stall_gnt", s_gnt, 2);
            end
            advance();
        end
        chk("t3_ack_cycles", mask, 32'h42);
        mode = 1;
        repeat (6) tick();
        chk("t3_sb_empty", exp_q.size(), 0);
        chk("t3_idle", s_busy, 0);
        thr_en = 1'b1;

        // Threshold shortening: level held at 8.
        mode = 2; fcnt = 8;
        start_trace();
        load(0, 2, 8'h70);
        load(1, 2, 8'h78);
        repeat (10) tick();
        chk("t4_bursts", b_gnt.size(), 4);
        if (b_gnt.size() >= 4) begin
            for (int k = 0; k < 4; k++) begin
                chk("t4_gnt_alt", b_gnt[k], k % 2);
                chk("t4_burst_len", b_len[k], 1);
            end
        end
        chk("t4_sb_empty", exp_q.size(), 0);

        // Early release by requester 3 after two beats.
        mode = 1; fcnt = 0;
        start_trace();
        load(3, 2, 8'h80);
        tick();
        load(1, 1, 8'h90);
        load(2, 1, 8'hA0);
        repeat (11) tick();
        chk("t5_bursts", b_gnt.size(), 3);
        if (b_gnt.size() >= 3) begin
            chk("t5_first_gnt", b_gnt[0], 3);
            chk("t5_first_len", b_len[0], 2);
            chk("t5_next_gnt", b_gnt[1], 1);
            chk("t5_third_gnt", b_gnt[2], 2);
        end
        chk("t5_sb_empty", exp_q.size(), 0);

        // Asynchronous reset during beat 2.
        mode = 1; fcnt = 0;
        start_trace();
        load(2, 4, 8'hB0);
        tick();
        tick();
        sample();
        chk("t6_beat2_live", s_wr, 1);
        reset = 1'b0;
        #1;
        chk("t6_rst_wrEn", wrEn, 0);
        chk("t6_rst_ack", ack, 0);
        chk("t6_rst_busy", busy, 0);
        chk("t6_rst_gnt", gnt_id, 0);
        for (int i = 0; i < N_REQ; i++) rem[i] = 0;
        exp_q.delete();
        fcnt = 0;
        drive();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        start_trace();
        load(2, 1, 8'hC0);
        load(3, 1, 8'hC8);
        repeat (7) tick();
        chk("t6_bursts", b_gnt.size(), 2);
        if (b_gnt.size() >= 2) begin
            chk("t6_first_gnt", b_gnt[0], 2);
            chk("t6_second_gnt", b_gnt[1], 3);
        end
        chk("t6_sb_empty", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Shares the single 16x8 FIFO write port between N_REQ producers.
- Round-robin arbitration with bounded bursts; gates every write with fifo_full so each ack is a guaranteed FIFO write.
- fifo_threshold (FIFO at least half full) shortens bursts to limit hogging.
- Sits between the producer blocks and the FIFO top's wrEn/data_in inputs.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- DW, 8, data width; must match the FIFO data width.
- MAX_BURST, 4, maximum consecutive beats per grant (1..16).

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- req  input  N_REQ  per-requester write request; held high with data stable until acked.
- req_data  input  N_REQ*DW  requester i data in bits [i*DW +: DW].
- fifo_full  input  1  FIFO full flag, combinational from FIFO pointers.
- fifo_threshold  input  1  FIFO at or above half full.
- wrEn  output  1  FIFO write enable.
- data_in  output  DW  FIFO write data.
- ack  output  N_REQ  one-hot; beat from requester i written this cycle.
- gnt_id  output  clog2(N_REQ)  currently or last granted requester.
- busy  output  1  high while in BURST.

Behaviour:
- Reset values:
  - State IDLE; rr_ptr=0, gnt_id=0, beat_cnt=0.
  - wrEn=0, ack=0, busy=0. data_in is don't-care, driven from the gnt_id=0 slice.
- IDLE:
  - Entry condition: any req bit high and fifo_full=0.
  - Winner is the first set req bit scanning upward from rr_ptr, wrapping modulo N_REQ.
  - At the clock edge: gnt_id<=winner, beat_cnt<=0, state<=BURST.
  - No write occurs in IDLE.
- BURST:
  - busy=1.
  - wrEn = req[gnt_id] & ~fifo_full.
  - ack[gnt_id] = wrEn; all other ack bits are 0.
  - data_in = req_data slice gnt_id, combinational.
- Accepted beat (wrEn=1): beat_cnt increments.
- BURST exits to IDLE at the edge when any of these hold:
  - (a) req[gnt_id]=0 this cycle; no write in that cycle.
  - (b) Accepted beat with beat_cnt+1 == MAX_BURST.
  - (c) Accepted beat with fifo_threshold=1 sampled in the same cycle; that beat completes and the burst ends.
- fifo_full=1 in BURST: stall. No ack, grant held, beat_cnt unchanged. This does not end the burst.
- On every BURST exit: rr_ptr <= (gnt_id+1) mod N_REQ.
  - The just-served requester therefore has lowest priority next round.
- Latency:
  - req rising in IDLE (FIFO not full) gives the first ack on the next cycle (1-cycle arbitration bubble).
  - Back-to-back bursts have one IDLE bubble between them.
- Throughput: one beat per cycle within a burst.
- No write is ever issued while fifo_full=1, so the FIFO never raises overflow due to this block.
- A requester dropping req without an ack is legal and ends its burst; no data is lost on the FIFO side.
- Asynchronous reset mid-burst:
  - Immediate return to reset values; wrEn drops asynchronously.
  - A beat acked in the reset cycle is not guaranteed written.
- N_REQ=1: degenerate case; rr_ptr stays 0 and behaviour is otherwise identical.

Decomposition:
- Shared package fifo_arb_pkg:
  - State enum {ARB_IDLE, ARB_BURST}.
  - Width function for clog2(N_REQ).
  - Constant default MAX_BURST.
- One sub-module, rr_pick: combinational round-robin priority picker.
  - Inputs: req vector, rr_ptr.
  - Outputs: winner index, any_valid.
  - Reusable for a future read-side scheduler.

Test Plan:
1. Single requester streaming.
   - Stimulus: reset, then req=4'b0001 held, data 0x10..0x15; FIFO empty, threshold low.
   - Required: ack on cycles 1-4; IDLE bubble; ack on cycles 6-7. FIFO holds 0x10..0x15 in order.
2. Fairness.
   - Stimulus: req=4'b1111 held continuously, MAX_BURST=4.
   - Required: grants ordered 0,1,2,3,0; exactly 4 acks per grant; gnt_id sequence observable.
3. Full stall.
   - Stimulus: FIFO preloaded to 15 entries; requester 2 sends 3 beats; reader pops one entry 5 cycles later.
   - Required: one ack, then wrEn=0 while full with busy=1 and gnt_id=2; ack resumes the cycle after the pop. Overflow never asserts.
4. Threshold shortening.
   - Stimulus: FIFO at 8 entries (threshold=1); req=4'b0011.
   - Required: each grant delivers exactly 1 beat; grants alternate 0,1,0,1.
5. Early release.
   - Stimulus: requester 3 drops req after 2 acks.
   - Required: burst ends with 2 beats and rr_ptr=0; the next grant goes to the lowest pending requester from 0.
6. Reset mid-burst.
   - Stimulus: reset low during beat 2 of a burst.
   - Required: wrEn, ack and busy go to 0 immediately; after release, the first grant starts from requester 0.
